// File: rtl/mem_stack_controller.sv
// ----------------------------------------------------------------------------
// mem_stack_controller: single-port RAM with addressed R/W, hardware stack, CLEAR
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_stack_controller #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           inst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 full,
  output logic                 empty,
  output logic                 err,
  output logic [ADDR_BITS:0]   sp
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_READ  = 4'd1;
  localparam logic [3:0] OP_WRITE = 4'd2;
  localparam logic [3:0] OP_PUSH  = 4'd3;
  localparam logic [3:0] OP_POP   = 4'd4;
  localparam logic [3:0] OP_PEEK  = 4'd5;
  localparam logic [3:0] OP_CLEAR = 4'd6;

  localparam logic [ADDR_BITS:0]   SP_FULL  = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   SP_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] CNT_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] CNT_LAST = {ADDR_BITS{1'b1}};

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  logic [DATA_BITS-1:0] mem [DEPTH];

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [ADDR_BITS:0]   sp_q, sp_d;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [ADDR_BITS:0]   sp_dec;
  logic                 is_full;
  logic                 is_empty;

  assign sp_dec   = sp_q - SP_ONE;
  assign is_full  = (sp_q == SP_FULL);
  assign is_empty = (sp_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sp_d        = sp_q;
    err_d       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = addr;
    mem_we      = 1'b0;
    mem_waddr   = addr;
    mem_wdata   = data_in;

    case (state_q)
      IDLE: begin
        case (inst)
          OP_NOP: ;
          OP_READ: rd_en = 1'b1;
          OP_WRITE: mem_we = 1'b1;
          OP_PUSH: begin
            if (is_full) begin
              err_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = sp_q[ADDR_BITS-1:0];
              sp_d      = sp_q + SP_ONE;
            end
          end
          OP_POP, OP_PEEK: begin
            if (is_empty) begin
              err_d = 1'b1;
            end else begin
              rd_en   = 1'b1;
              rd_addr = sp_dec[ADDR_BITS-1:0];
              if (inst == OP_POP) sp_d = sp_dec;
            end
          end
          OP_CLEAR: begin
            state_d = CLEARING;
            cnt_d   = '0;
            sp_d    = '0;
          end
          default: err_d = 1'b1;
        endcase
      end
      CLEARING: begin
        // Instruction bus is ignored entirely while sweeping the array.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = rd_en;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sp_q        <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      if (rd_en) data_out_q <= mem[rd_addr];
    end
  end

  // Array is not reset, but writes are gated so a reset aborts CLEAR cleanly.
  always_ff @(posedge clock) begin
    if (reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign sp        = sp_q;
  assign busy      = (state_q == CLEARING);
  assign full      = is_full;
  assign empty     = is_empty;

endmodule

`default_nettype wire

// File: tb/tb_mem_stack_controller.sv
// Self-checking bench for mem_stack_controller (DATA_BITS=8, ADDR_BITS=4).
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stack_controller;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  localparam logic [3:0] NOP = 4'd0, RD = 4'd1, WR = 4'd2, PUSH = 4'd3,
                         POP = 4'd4, PEEK = 4'd5, CLR = 4'd6;

  logic          clock   = 1'b0;
  logic          reset   = 1'b0;
  logic [3:0]    inst    = 4'd0;
  logic [AW-1:0] addr    = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          out_valid, busy, full, empty, err;
  logic [AW:0]   sp;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_stack_controller #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .inst     (inst),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .out_valid(out_valid),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .err      (err),
    .sp       (sp)
  );

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] dout;
    logic          v;
    logic          e;
    logic [AW:0]   sp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic [3:0] op,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    reset   = rst_n;
    inst    = op;
    addr    = a;
    data_in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic [DW-1:0] dout, input logic v,
                             input logic e, input logic [AW:0] s, input logic b);
    check({tag, ".data_out"}, 32'(data_out), 32'(dout));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".err"}, 32'(err), 32'(e));
    check({tag, ".sp"}, 32'(sp), 32'(s));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".full"}, 32'(full), 32'(s == 5'd16));
    check({tag, ".empty"}, 32'(empty), 32'(s == 5'd0));
  endtask

  initial begin
    int busy_cycles;

    vecs.push_back('{WR,   4'd3, 8'hA5, 8'h00, 1'b0, 1'b0, 5'd0});
    vecs.push_back('{RD,   4'd3, 8'h00, 8'hA5, 1'b1, 1'b0, 5'd0});
    vecs.push_back('{NOP,  4'd0, 8'h00, 8'hA5, 1'b0, 1'b0, 5'd0});
    vecs.push_back('{POP,  4'd0, 8'h00, 8'hA5, 1'b0, 1'b1, 5'd0});
    vecs.push_back('{PUSH, 4'd0, 8'h11, 8'hA5, 1'b0, 1'b0, 5'd1});
    vecs.push_back('{PUSH, 4'd0, 8'h22, 8'hA5, 1'b0, 1'b0, 5'd2});
    vecs.push_back('{PUSH, 4'd0, 8'h33, 8'hA5, 1'b0, 1'b0, 5'd3});
    vecs.push_back('{PEEK, 4'd0, 8'h00, 8'h33, 1'b1, 1'b0, 5'd3});
    vecs.push_back('{POP,  4'd0, 8'h00, 8'h33, 1'b1, 1'b0, 5'd2});
    vecs.push_back('{POP,  4'd0, 8'h00, 8'h22, 1'b1, 1'b0, 5'd1});
    vecs.push_back('{POP,  4'd0, 8'h00, 8'h11, 1'b1, 1'b0, 5'd0});
    vecs.push_back('{PEEK, 4'd0, 8'h00, 8'h11, 1'b0, 1'b1, 5'd0});
    vecs.push_back('{4'd9, 4'd0, 8'h00, 8'h11, 1'b0, 1'b1, 5'd0});
    vecs.push_back('{4'd15,4'd0, 8'h00, 8'h11, 1'b0, 1'b1, 5'd0});
    vecs.push_back('{PUSH, 4'd0, 8'h77, 8'h11, 1'b0, 1'b0, 5'd1});
    vecs.push_back('{WR,   4'd0, 8'h66, 8'h11, 1'b0, 1'b0, 5'd1});
    vecs.push_back('{POP,  4'd0, 8'h00, 8'h66, 1'b1, 1'b0, 5'd0});
    vecs.push_back('{WR,   4'd7, 8'hC3, 8'h66, 1'b0, 1'b0, 5'd0});
    vecs.push_back('{RD,   4'd7, 8'h00, 8'hC3, 1'b1, 1'b0, 5'd0});
    vecs.push_back('{RD,   4'd3, 8'h00, 8'hA5, 1'b1, 1'b0, 5'd0});

    // Reset state, then POP on an empty stack.
    step(1'b0, NOP, '0, '0);
    step(1'b0, NOP, '0, '0);
    expect_outs("reset", 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b1, POP, '0, '0);
    expect_outs("pop_empty", 8'h00, 1'b0, 1'b1, 5'd0, 1'b0);
    step(1'b1, NOP, '0, '0);
    expect_outs("pop_empty_after", 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].d);
      expect_outs($sformatf("vec%0d", i), vecs[i].dout, vecs[i].v, vecs[i].e, vecs[i].sp, 1'b0);
    end

    // Fill the stack to DEPTH, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, PUSH, '0, 8'(8'h10 + i));
      check($sformatf("fill_sp%0d", i), 32'(sp), 32'(i + 1));
      check($sformatf("fill_err%0d", i), 32'(err), 32'd0);
    end
    expect_outs("full", 8'hA5, 1'b0, 1'b0, 5'd16, 1'b0);
    step(1'b1, PUSH, '0, 8'hFF);
    expect_outs("push_full", 8'hA5, 1'b0, 1'b1, 5'd16, 1'b0);
    step(1'b1, RD, 4'd0, '0);
    expect_outs("read0", 8'h10, 1'b1, 1'b0, 5'd16, 1'b0);
    step(1'b1, RD, 4'd15, '0);
    expect_outs("read15", 8'h1F, 1'b1, 1'b0, 5'd16, 1'b0);

    // Full CLEAR with writes/pushes offered throughout.
    step(1'b1, CLR, '0, '0);
    expect_outs("clr_enter", 8'h1F, 1'b0, 1'b0, 5'd0, 1'b1);
    busy_cycles = 1;
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b1, (k % 2) ? WR : PUSH, 4'd2, 8'hEE);
      if (busy) busy_cycles++;
      expect_outs($sformatf("clr%0d", k), 8'h1F, 1'b0, 1'b0, 5'd0, k < DEPTH);
    end
    check("busy_cycles", 32'(busy_cycles), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, RD, AW'(i), '0);
      check($sformatf("cleared%0d", i), 32'(data_out), 32'h0);
      check($sformatf("cleared_v%0d", i), 32'(out_valid), 32'd1);
    end

    // CLEAR aborted by reset after five busy cycles.
    for (int i = 0; i < DEPTH; i++) step(1'b1, WR, AW'(i), 8'(8'h80 + i));
    step(1'b1, CLR, '0, '0);
    for (int k = 0; k < 5; k++) step(1'b1, NOP, '0, '0);
    check("abort_busy_pre", 32'(busy), 32'd1);
    step(1'b0, NOP, '0, '0);
    expect_outs("abort_reset", 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, RD, AW'(i), '0);
      check($sformatf("abort_rd%0d", i), 32'(data_out), (i < 5) ? 32'h0 : 32'(8'h80 + i));
    end
    step(1'b1, 4'd9, '0, '0);
    expect_outs("reserved9", 8'h8F, 1'b0, 1'b1, 5'd0, 1'b0);
    step(1'b1, NOP, '0, '0);
    expect_outs("reserved9_after", 8'h8F, 1'b0, 1'b0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
